win_3x3_gen: RTL
================

# win_3x3_gen

Streaming 3x3 neighbourhood generator feeding the DPC median/detection stage. It accepts one raster-order pixel per qualified cycle. Two on-chip line buffers hold the previous two image lines, and a 3x3 shift-register window is built from them. Each complete interior window is emitted as three 24-bit row taps plus a valid strobe, in the packing the DPC 3x3 kernels consume.

## Interface
Parameters:
- IMG_W, 640, active pixels per line (≥3)
- IMG_H, 480, active lines per frame (≥3)
- DW, 8, pixel width (fixed at 8 for DPC; taps are 3*DW wide)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- i_pix_valid  in  1  pixel qualifier; all state advances only when high
- i_pix_data  in  8  unsigned pixel
- i_sof  in  1  start of frame; meaningful only with i_pix_valid, marks pixel (row 0, col 0)
- o_win_valid  out  1  window taps valid this cycle
- o_line3_1  out  24  top row (line r-2): [23:16]=col c-2, [15:8]=c-1, [7:0]=c
- o_line3_2  out  24  middle row (line r-1), same column packing
- o_line3_3  out  24  bottom row (current line r), same column packing
- o_win_last  out  1  with o_win_valid, marks last window of frame (r=IMG_H-1, c=IMG_W-1)

## Operation
- col counter 0..IMG_W-1 and row counter 0..IMG_H-1 advance on each accepted pixel (i_pix_valid=1). col wraps at IMG_W-1 and row increments. After (IMG_H-1, IMG_W-1) both wrap to 0.
- i_sof with i_pix_valid forces the accepted pixel to (0,0), overriding the counters mid-frame.
- Line buffers LB0 (line r-1) and LB1 (line r-2) are IMG_W deep, read-before-write at address col.
  - On acceptance: LB0[col] ← pixel; LB1[col] ← old LB0[col].
  - The column triple {LB1 old, LB0 old, pixel} shifts into the window: bits [7:0] receive the new column and the oldest column drops out.
- FSM:
  - IDLE (after reset): pixels are ignored until i_sof&&i_pix_valid, which moves to FILL and accepts that pixel as (0,0).
  - FILL: rows 0–1. No output. Moves to RUN when an accepted pixel has row=2, col=0.
  - RUN: o_win_valid=1 for an accepted pixel with row≥2 and col≥2. Moves to FILL on wrap to (0,0) or on a new sof.
- Windows never straddle lines: the col≥2 gating discards the two columns carried over from the previous line. No border padding. The frame yields (IMG_W-2)*(IMG_H-2) windows.
- Stall: i_pix_valid=0 holds counters, window and FSM, and forces o_win_valid=0.

## Timing
- Reset values: o_win_valid=0, o_win_last=0, all o_line3_* = 0, counters 0, FSM=IDLE. Line buffer contents are not cleared; they are overwritten during FILL before use.
- Latency is 1 clk: the pixel accepted at edge N yields its window on the outputs registered at edge N+1. o_win_valid is a single-cycle strobe per accepted window.
- Throughput is 1 window/clk in RUN with continuous i_pix_valid.
- o_line3_* hold their last value while o_win_valid=0.
- Reset mid-frame: outputs return to reset values immediately. Output resumes only after the next sof plus 2 full lines.
- sof mid-frame: the partial frame is abandoned, with no o_win_last for it. The FSM restarts FILL with that pixel at (0,0), and no window from the old frame is emitted afterwards.
- Frame wrap without sof: treated as a new frame identically.

## Structure
- Shared header isp_defs.vh: pixel width DW_PIX=8, tap width 3*DW_PIX, and FSM state encodings WG_IDLE/WG_FILL/WG_RUN.
- One sub-module, line_buf_ram.
  - Single-port, read-before-write, registered read, DEPTH/DW parameters.
  - Two instances, LB0 and LB1.
  - Read address is presented one cycle ahead, or a combinational read is used, so that the 1-clk latency holds.

## Test plan
- Parameters IMG_W=5, IMG_H=4; pixel=row*16+col, continuous valid, one frame. Required response:
  - Exactly 6 o_win_valid pulses.
  - First window: o_line3_1=0x000102, o_line3_2=0x101112, o_line3_3=0x202122.
  - Last window: 0x121314/0x222324/0x323334, with o_win_last=1 on that pulse only.
- Same frame with i_pix_valid randomly deasserted for 30% of cycles: identical 6 windows in order, no valid during stalls.
- sof asserted at (2,1) of frame 1, then a full clean frame: no windows emitted after the sof until the new row 2 col 2, then exactly 6 correct windows.
- reset_n pulsed low at (3,2): all outputs 0 on the next sample. Pixels without sof produce no windows (IDLE). A following frame with sof produces 6 correct windows.
- Two back-to-back frames without gaps or second sof (wrap): 12 windows total. The second frame's first window is built only from second-frame data, with no first-frame pixels in the taps.
- IMG_W=640, IMG_H=480, random data, against a reference model: 638*478 windows, all taps match, o_win_last once.

Source files
------------

// File: rtl/win_3x3_gen_pkg.sv
// Shared definitions for the 3x3 window generator: pixel/tap widths and FSM encoding.
package win_3x3_gen_pkg;

  localparam int unsigned DW_PIX = 8;
  localparam int unsigned TAP_W  = 3 * DW_PIX;

  typedef enum logic [1:0] {
    WG_IDLE,
    WG_FILL,
    WG_RUN
  } wg_state_e;

endpackage

// File: rtl/line_buf_ram.sv
// Single-port line buffer: synchronous write, combinational read-before-write at the same
// address, so the old word is available in the same cycle the new one is written.
module line_buf_ram #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned DW    = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/win_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a column shift window,
// emitting interior windows as three packed row taps one clock after the pixel is accepted.
module win_3x3_gen
  import win_3x3_gen_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned DW    = DW_PIX
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_pix_valid,
  input  logic [DW-1:0]   i_pix_data,
  input  logic            i_sof,
  output logic            o_win_valid,
  output logic [3*DW-1:0] o_line3_1,
  output logic [3*DW-1:0] o_line3_2,
  output logic [3*DW-1:0] o_line3_3,
  output logic            o_win_last
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);

  wg_state_e       state_q, state_d;
  logic [CW-1:0]   col_q, col_d, pos_col;
  logic [RW-1:0]   row_q, row_d, pos_row;
  logic            sof_acc, accept, at_last, win_fire;
  logic [DW-1:0]   lb0_rd, lb1_rd;
  logic [2*DW-1:0] top_q, mid_q, bot_q;
  logic [3*DW-1:0] line1_q, line2_q, line3_q;
  logic            win_valid_q, win_last_q;

  // sof overrides the counters so the qualifying pixel always lands at (0,0)
  always_comb begin
    sof_acc = i_pix_valid && i_sof;
    accept  = i_pix_valid && ((state_q != WG_IDLE) || i_sof);
    pos_col = sof_acc ? '0 : col_q;
    pos_row = sof_acc ? '0 : row_q;
    at_last = (pos_col == COL_LAST) && (pos_row == ROW_LAST);

    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
      end else begin
        col_d = pos_col + CW'(1);
        row_d = pos_row;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    win_fire = 1'b0;
    unique case (state_q)
      WG_IDLE: begin
        if (sof_acc) state_d = WG_FILL;
      end
      WG_FILL: begin
        if (accept && (pos_row == ROW_TWO) && (pos_col == '0)) state_d = WG_RUN;
      end
      WG_RUN: begin
        if (accept) begin
          if (sof_acc || at_last) state_d = WG_FILL;
          // col>=2 drops the two columns carried over from the previous line
          win_fire = !sof_acc && (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);
        end
      end
      default: state_d = WG_IDLE;
    endcase
  end

  line_buf_ram #(
    .DEPTH (IMG_W),
    .DW    (DW)
  ) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (pos_col),
    .wdata (i_pix_data),
    .rdata (lb0_rd)
  );

  line_buf_ram #(
    .DEPTH (IMG_W),
    .DW    (DW)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (pos_col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WG_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
      line1_q     <= '0;
      line2_q     <= '0;
      line3_q     <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_fire;
      win_last_q  <= win_fire && at_last;
      if (accept) begin
        top_q <= {top_q[DW-1:0], lb1_rd};
        mid_q <= {mid_q[DW-1:0], lb0_rd};
        bot_q <= {bot_q[DW-1:0], i_pix_data};
      end
      // Taps only load on an emitted window so they hold between strobes
      if (win_fire) begin
        line1_q <= {top_q, lb1_rd};
        line2_q <= {mid_q, lb0_rd};
        line3_q <= {bot_q, i_pix_data};
      end
    end
  end

  assign o_win_valid = win_valid_q;
  assign o_win_last  = win_last_q;
  assign o_line3_1   = line1_q;
  assign o_line3_2   = line2_q;
  assign o_line3_3   = line3_q;

endmodule
